// File: rtl/ami_sched_pkg.sv
// Shared types and constants for the DMA job scheduler.
package ami_sched_pkg;

    // Per-channel sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StCfg,
        StBusy,
        StClr,
        StDrain,
        StDone
    } chan_state_e;

    // Requester direction encoding on req_dir.
    localparam logic DirW = 1'b1;
    localparam logic DirR = 1'b0;

    // Completion status codes reported on *done_err.
    localparam logic [3:0] ErrOk   = 4'h0;
    localparam logic [3:0] ErrLen0 = 4'h1;

endpackage

// File: rtl/ami_sched_chan.sv
// One DMA channel sequencer: round-robin grant, config handshake, irq clear, completion report.
module ami_sched_chan
    import ami_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ),
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] valid,
    input  logic [31:0]     sa  [NREQ],
    input  logic [31:0]     len [NREQ],
    output logic [NREQ-1:0] ready,
    output logic            cfg_valid,
    input  logic            cfg_ready,
    output logic [31:0]     cfg_sa,
    output logic [31:0]     cfg_len,
    input  logic            irq,
    input  logic [3:0]      err,
    output logic            w1c,
    output logic            done_valid,
    output logic [IDW-1:0]  done_id,
    output logic [3:0]      done_err,
    output logic            busy,
    output logic [CNTW-1:0] jobs
);

    chan_state_e     state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [31:0]     sa_q, sa_d;
    logic [31:0]     len_q, len_d;
    logic [3:0]      err_q, err_d;
    logic [CNTW-1:0] jobs_q, jobs_d;

    logic            found;
    logic [IDW-1:0]  grant;
    logic [IDW-1:0]  idx;
    logic [IDW-1:0]  ptr_next;

    // Circular search for the first eligible requester at or after ptr.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = IDW'((int'(ptr_q) + k) % int'(NREQ));
            if (!found && valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
        ptr_next = IDW'((int'(grant) + 1) % int'(NREQ));
    end

    // Next-state logic and per-state strobes.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        sa_d       = sa_q;
        len_d      = len_q;
        err_d      = err_q;
        jobs_d     = jobs_q;
        ready      = '0;
        cfg_valid  = 1'b0;
        w1c        = 1'b0;
        done_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    ready[grant] = 1'b1;
                    sa_d         = sa[grant];
                    len_d        = len[grant];
                    id_d         = grant;
                    ptr_d        = ptr_next;
                    if (len[grant] != '0) begin
                        err_d   = ErrOk;
                        state_d = StCfg;
                    end else begin
                        // Zero length never reaches the DMA port.
                        err_d   = ErrLen0;
                        state_d = StDone;
                    end
                end
            end
            StCfg: begin
                cfg_valid = 1'b1;
                if (cfg_ready) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (irq) begin
                    err_d   = err;
                    state_d = StClr;
                end
            end
            StClr: begin
                w1c     = 1'b1;
                state_d = StDrain;
            end
            StDrain: begin
                if (!irq) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_valid = 1'b1;
                jobs_d     = jobs_q + 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, pointer, job latches and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            id_q    <= '0;
            sa_q    <= '0;
            len_q   <= '0;
            err_q   <= ErrOk;
            jobs_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            sa_q    <= sa_d;
            len_q   <= len_d;
            err_q   <= err_d;
            jobs_q  <= jobs_d;
        end
    end

    assign cfg_sa   = sa_q;
    assign cfg_len  = len_q;
    assign done_id  = done_valid ? id_q : '0;
    assign done_err = done_valid ? err_q : '0;
    assign busy     = (state_q != StIdle);
    assign jobs     = jobs_q;

endmodule

// File: rtl/ami_dma_sched.sv
// DMA job scheduler: splits requesters by direction onto the write and read channel sequencers.
module ami_dma_sched
    import ami_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ),
    parameter int unsigned CNTW = 16
) (
    input  logic               usr_clk,
    input  logic               usr_reset_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_dir,
    input  logic [NREQ*32-1:0] req_sa,
    input  logic [NREQ*32-1:0] req_len,
    output logic               cfg_dmaw_valid,
    input  logic               cfg_dmaw_ready,
    output logic [31:0]        cfg_dmaw_sa,
    output logic [31:0]        cfg_dmaw_len,
    output logic               cfg_dmar_valid,
    input  logic               cfg_dmar_ready,
    output logic [31:0]        cfg_dmar_sa,
    output logic [31:0]        cfg_dmar_len,
    input  logic               dmaw_irq,
    input  logic [3:0]         dmaw_err,
    output logic               dmaw_irq_w1c,
    input  logic               dmar_irq,
    input  logic [3:0]         dmar_err,
    output logic               dmar_irq_w1c,
    output logic               wdone_valid,
    output logic [IDW-1:0]     wdone_id,
    output logic [3:0]         wdone_err,
    output logic               rdone_valid,
    output logic [IDW-1:0]     rdone_id,
    output logic [3:0]         rdone_err,
    output logic               wbusy,
    output logic               rbusy,
    output logic [CNTW-1:0]    wjobs,
    output logic [CNTW-1:0]    rjobs
);

    logic [31:0]     sa_arr  [NREQ];
    logic [31:0]     len_arr [NREQ];
    logic [NREQ-1:0] wvalid;
    logic [NREQ-1:0] rvalid;
    logic [NREQ-1:0] wready;
    logic [NREQ-1:0] rready;

    // Each requester is eligible on exactly one channel, chosen by its direction bit.
    for (genvar i = 0; i < int'(NREQ); i++) begin : g_unpack
        assign sa_arr[i]  = req_sa[32*i +: 32];
        assign len_arr[i] = req_len[32*i +: 32];
        assign wvalid[i]  = req_valid[i] && (req_dir[i] == DirW);
        assign rvalid[i]  = req_valid[i] && (req_dir[i] == DirR);
    end

    // Masks are disjoint, so the two grant vectors never overlap.
    assign req_ready = wready | rready;

    ami_sched_chan #(
        .NREQ (NREQ),
        .IDW  (IDW),
        .CNTW (CNTW)
    ) u_wchan (
        .clk        (usr_clk),
        .rst_n      (usr_reset_n),
        .valid      (wvalid),
        .sa         (sa_arr),
        .len        (len_arr),
        .ready      (wready),
        .cfg_valid  (cfg_dmaw_valid),
        .cfg_ready  (cfg_dmaw_ready),
        .cfg_sa     (cfg_dmaw_sa),
        .cfg_len    (cfg_dmaw_len),
        .irq        (dmaw_irq),
        .err        (dmaw_err),
        .w1c        (dmaw_irq_w1c),
        .done_valid (wdone_valid),
        .done_id    (wdone_id),
        .done_err   (wdone_err),
        .busy       (wbusy),
        .jobs       (wjobs)
    );

    ami_sched_chan #(
        .NREQ (NREQ),
        .IDW  (IDW),
        .CNTW (CNTW)
    ) u_rchan (
        .clk        (usr_clk),
        .rst_n      (usr_reset_n),
        .valid      (rvalid),
        .sa         (sa_arr),
        .len        (len_arr),
        .ready      (rready),
        .cfg_valid  (cfg_dmar_valid),
        .cfg_ready  (cfg_dmar_ready),
        .cfg_sa     (cfg_dmar_sa),
        .cfg_len    (cfg_dmar_len),
        .irq        (dmar_irq),
        .err        (dmar_err),
        .w1c        (dmar_irq_w1c),
        .done_valid (rdone_valid),
        .done_id    (rdone_id),
        .done_err   (rdone_err),
        .busy       (rbusy),
        .jobs       (rjobs)
    );

endmodule

// File: tb/tb_ami_dma_sched.sv
// Directed bench for ami_dma_sched with simple DMA responder models on both channels.
module tb_ami_dma_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 16;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_dir;
    logic [NREQ*32-1:0] req_sa;
    logic [NREQ*32-1:0] req_len;
    logic               cfg_dmaw_valid, cfg_dmaw_ready;
    logic [31:0]        cfg_dmaw_sa, cfg_dmaw_len;
    logic               cfg_dmar_valid, cfg_dmar_ready;
    logic [31:0]        cfg_dmar_sa, cfg_dmar_len;
    logic               dmaw_irq, dmar_irq;
    logic [3:0]         dmaw_err, dmar_err;
    logic               dmaw_irq_w1c, dmar_irq_w1c;
    logic               wdone_valid, rdone_valid;
    logic [IDW-1:0]     wdone_id, rdone_id;
    logic [3:0]         wdone_err, rdone_err;
    logic               wbusy, rbusy;
    logic [CNTW-1:0]    wjobs, rjobs;

    ami_dma_sched #(
        .NREQ (NREQ),
        .IDW  (IDW),
        .CNTW (CNTW)
    ) dut (
        .usr_clk        (clk),
        .usr_reset_n    (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_dir        (req_dir),
        .req_sa         (req_sa),
        .req_len        (req_len),
        .cfg_dmaw_valid (cfg_dmaw_valid),
        .cfg_dmaw_ready (cfg_dmaw_ready),
        .cfg_dmaw_sa    (cfg_dmaw_sa),
        .cfg_dmaw_len   (cfg_dmaw_len),
        .cfg_dmar_valid (cfg_dmar_valid),
        .cfg_dmar_ready (cfg_dmar_ready),
        .cfg_dmar_sa    (cfg_dmar_sa),
        .cfg_dmar_len   (cfg_dmar_len),
        .dmaw_irq       (dmaw_irq),
        .dmaw_err       (dmaw_err),
        .dmaw_irq_w1c   (dmaw_irq_w1c),
        .dmar_irq       (dmar_irq),
        .dmar_err       (dmar_err),
        .dmar_irq_w1c   (dmar_irq_w1c),
        .wdone_valid    (wdone_valid),
        .wdone_id       (wdone_id),
        .wdone_err      (wdone_err),
        .rdone_valid    (rdone_valid),
        .rdone_id       (rdone_id),
        .rdone_err      (rdone_err),
        .wbusy          (wbusy),
        .rbusy          (rbusy),
        .wjobs          (wjobs),
        .rjobs          (rjobs)
    );

    int total = 0;
    int bad   = 0;

    // Responder knobs: cycles from config to irq, cycles irq stays up after w1c, error code.
    int         wdelay = 20, whold = 1, rdelay = 2, rhold = 0;
    logic [3:0] werr_cfg = 4'h0, rerr_cfg = 4'h0;

    // Observed events, collected on the falling edge.
    int cyc = 0;
    int wclr_cnt = 0, rclr_cnt = 0, wcfg_cnt = 0;
    int rclr_cyc = 0, rdone_cyc = 0;
    int wid_q[$], werr_q[$], rid_q[$], rerr_q[$], rgrant_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_job(input int i, input logic dir, input logic [31:0] sa,
                           input logic [31:0] len);
        req_dir[i]          = dir;
        req_sa[32*i +: 32]  = sa;
        req_len[32*i +: 32] = len;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input bit is_w, input int n, input int lim);
        int k;
        k = 0;
        while (((is_w ? wid_q.size() : rid_q.size()) < n) && k < lim) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(tag, 64'((is_w ? wid_q.size() : rid_q.size()) >= n), 64'd1);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (dmaw_irq_w1c) wclr_cnt++;
            if (dmar_irq_w1c) begin
                rclr_cnt++;
                rclr_cyc = cyc;
            end
            if (cfg_dmaw_valid) wcfg_cnt++;
            if (wdone_valid) begin
                wid_q.push_back(int'(wdone_id));
                werr_q.push_back(int'(wdone_err));
            end
            if (rdone_valid) begin
                rid_q.push_back(int'(rdone_id));
                rerr_q.push_back(int'(rdone_err));
                rdone_cyc = cyc;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && !req_dir[i]) rgrant_q.push_back(i);
            end
        end
    end

    // Write DMA model: irq after wdelay, held until w1c plus whold cycles.
    initial begin
        dmaw_irq = 1'b0;
        dmaw_err = 4'h0;
        forever begin
            @(negedge clk);
            if (cfg_dmaw_valid && cfg_dmaw_ready) begin
                repeat (wdelay) @(negedge clk);
                dmaw_irq = 1'b1;
                dmaw_err = werr_cfg;
                for (int k = 0; k < 40 && !dmaw_irq_w1c; k++) @(negedge clk);
                repeat (whold) @(negedge clk);
                dmaw_irq = 1'b0;
                dmaw_err = 4'h0;
            end
        end
    end

    // Read DMA model, same behaviour.
    initial begin
        dmar_irq = 1'b0;
        dmar_err = 4'h0;
        forever begin
            @(negedge clk);
            if (cfg_dmar_valid && cfg_dmar_ready) begin
                repeat (rdelay) @(negedge clk);
                dmar_irq = 1'b1;
                dmar_err = rerr_cfg;
                for (int k = 0; k < 40 && !dmar_irq_w1c; k++) @(negedge clk);
                repeat (rhold) @(negedge clk);
                dmar_irq = 1'b0;
                dmar_err = 4'h0;
            end
        end
    end

    initial begin
        int base_r, base_c;
        rst_n          = 1'b0;
        req_valid      = '0;
        req_dir        = '0;
        req_sa         = '0;
        req_len        = '0;
        cfg_dmaw_ready = 1'b1;
        cfg_dmar_ready = 1'b1;
        #1;
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_wcfg", 64'(cfg_dmaw_valid), 64'h0);
        check("rst_wbusy", 64'(wbusy), 64'h0);
        check("rst_rbusy", 64'(rbusy), 64'h0);
        check("rst_wjobs", 64'(wjobs), 64'h0);
        check("rst_rjobs", 64'(rjobs), 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Single write job from requester 2.
        set_job(2, 1'b1, 32'h1000, 32'h200);
        req_valid = 4'b0100;
        #1;
        check("t1_ready", 64'(req_ready), 64'h4);
        cycle();
        req_valid = '0;
        check("t1_cfg_valid", 64'(cfg_dmaw_valid), 64'h1);
        check("t1_cfg_sa", 64'(cfg_dmaw_sa), 64'h1000);
        check("t1_cfg_len", 64'(cfg_dmaw_len), 64'h200);
        wait_done("t1_timeout", 1'b1, 1, 100);
        check("t1_id", 64'(wid_q[0]), 64'd2);
        check("t1_err", 64'(werr_q[0]), 64'd0);
        check("t1_w1c_count", 64'(wclr_cnt), 64'd1);
        check("t1_cfg_cycles", 64'(wcfg_cnt), 64'd1);
        cycle();
        check("t1_wjobs", 64'(wjobs), 64'd1);

        // All four requesters post reads continuously.
        for (int i = 0; i < NREQ; i++) set_job(i, 1'b0, 32'h100 * i, 32'h10 * (i + 1));
        rdelay    = 2;
        rhold     = 0;
        req_valid = 4'hF;
        wait_done("t2_timeout", 1'b0, 5, 200);
        req_valid = '0;
        check("t2_grant_count", 64'(rgrant_q.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_grant%0d", i), 64'(rgrant_q[i]), 64'(i % 4));
            check($sformatf("t2_done%0d", i), 64'(rid_q[i]), 64'(i % 4));
        end
        cycle();
        check("t2_rjobs", 64'(rjobs), 64'd5);

        // Concurrent write (req 0) and read (req 1).
        wdelay = 4;
        whold  = 0;
        set_job(0, 1'b1, 32'hA000, 32'h80);
        set_job(1, 1'b0, 32'hB000, 32'h40);
        req_valid = 4'b0011;
        #1;
        check("t3_ready", 64'(req_ready), 64'h3);
        cycle();
        req_valid = '0;
        check("t3_rcfg_sa", 64'(cfg_dmar_sa), 64'hB000);
        wait_done("t3_wtimeout", 1'b1, 2, 100);
        wait_done("t3_rtimeout", 1'b0, 6, 100);
        check("t3_wid", 64'(wid_q[1]), 64'd0);
        check("t3_rid", 64'(rid_q[5]), 64'd1);
        cycle();

        // Zero-length write from requester 3: DMA port is never touched.
        base_c = wcfg_cnt;
        set_job(3, 1'b1, 32'hC000, 32'h0);
        req_valid = 4'b1000;
        #1;
        check("t4_ready", 64'(req_ready), 64'h8);
        cycle();
        req_valid = '0;
        check("t4_done_valid", 64'(wdone_valid), 64'h1);
        check("t4_done_id", 64'(wdone_id), 64'd3);
        check("t4_done_err", 64'(wdone_err), 64'h1);
        cycle();
        check("t4_idle", 64'(wbusy), 64'h0);
        check("t4_no_cfg", 64'(wcfg_cnt - base_c), 64'd0);
        check("t4_wjobs", 64'(wjobs), 64'd3);

        // Read error code with irq held 5 cycles past the clear pulse.
        base_r   = rclr_cnt;
        rerr_cfg = 4'h2;
        rhold    = 5;
        set_job(2, 1'b0, 32'hD000, 32'h20);
        req_valid = 4'b0100;
        cycle();
        req_valid = '0;
        wait_done("t5_timeout", 1'b0, 7, 100);
        check("t5_err", 64'(rerr_q[6]), 64'h2);
        check("t5_w1c_count", 64'(rclr_cnt - base_r), 64'd1);
        check("t5_drain_wait", 64'(rdone_cyc - rclr_cyc), 64'd6);
        rerr_cfg = 4'h0;
        rhold    = 0;
        cycle();
        check("t5_rjobs", 64'(rjobs), 64'd7);

        // Reset while the write channel waits in BUSY.
        wdelay = 60;
        set_job(1, 1'b1, 32'hE000, 32'h100);
        req_valid = 4'b0010;
        cycle();
        req_valid = '0;
        repeat (5) cycle();
        check("t6_busy_pre", 64'(wbusy), 64'h1);
        check("t6_wjobs_pre", 64'(wjobs), 64'd3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_wbusy", 64'(wbusy), 64'h0);
        check("t6_rst_wjobs", 64'(wjobs), 64'h0);
        check("t6_rst_rjobs", 64'(rjobs), 64'h0);
        check("t6_rst_sa", 64'(cfg_dmaw_sa), 64'h0);
        check("t6_rst_len", 64'(cfg_dmaw_len), 64'h0);
        check("t6_rst_w1c", 64'(dmaw_irq_w1c), 64'h0);
        check("t6_rst_done", 64'(wdone_valid), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base_c = wclr_cnt;
        // The stale irq from the aborted job arrives and leaves while idle.
        repeat (110) cycle();
        check("t6_stale_no_clr", 64'(wclr_cnt - base_c), 64'd0);
        check("t6_stale_idle", 64'(wbusy), 64'h0);
        check("t6_no_done", 64'(wid_q.size()), 64'd3);
        wdelay = 3;
        req_valid = 4'b0010;
        cycle();
        req_valid = '0;
        wait_done("t6_timeout", 1'b1, 4, 100);
        check("t6_id", 64'(wid_q[3]), 64'd1);
        check("t6_err", 64'(werr_q[3]), 64'd0);
        cycle();
        check("t6_wjobs", 64'(wjobs), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
